// File: rtl/seg_bcd_writer.sv
// seg_bcd_writer
// Converts a binary value to six BCD digits (sequential double-dabble) or
// six hex nibbles. It then writes them as APB transfers to digit registers
// 0x0..0x5 of the seven-segment display peripheral.
//
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : update request, sampled only while idle
//   bin_value      : value to display
//   hex_mode       : 1 = five hex nibbles plus a zero digit 5, 0 = decimal
//   dp_mask        : decimal-point enable, bit i -> digit i
//   busy, done     : operation in progress / one-cycle completion pulse
//   ovf            : last decimal request saturated to SAT_VAL
//   psel, penable, paddr, pwrite, pwdata : APB write master (no pready)
module seg_bcd_writer #(
    parameter int unsigned BIN_W   = 20,
    parameter int unsigned SAT_VAL = 999999
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_value,
    input  logic             hex_mode,
    input  logic [5:0]       dp_mask,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             psel,
    output logic             penable,
    output logic [3:0]       paddr,
    output logic             pwrite,
    output logic [31:0]      pwdata
);

    localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [BIN_W-1:0] SAT_BIN = BIN_W'(SAT_VAL);
    localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(BIN_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_SETUP,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [BIN_W-1:0] r_bin;
    logic [23:0]      r_bcd;
    logic [5:0]       r_dp;
    logic [2:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;

    logic [23:0]      w_adj;
    logic [23:0]      w_bcd_next;
    logic [23:0]      w_hex_bcd;
    logic             w_over;

    // Double-dabble add-3 step on every BCD digit.
    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < 6; d++) begin
            if (r_bcd[d*4 +: 4] >= 4'd5) begin
                w_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
            end
        end
    end

    // The binary MSB shifts into BCD bit 0.
    assign w_bcd_next = {w_adj[22:0], r_bin[BIN_W-1]};
    assign w_hex_bcd  = {4'h0, 20'(bin_value)};
    assign w_over     = (bin_value > SAT_BIN);

    // Digit register write data: decimal point in bit 7, digit in [3:0].
    function automatic logic [31:0] f_word(input logic [23:0] bcd,
                                           input logic [2:0]  idx,
                                           input logic [5:0]  dp);
        logic [3:0] dig;
        logic       dpb;
        dig = bcd[{idx, 2'b00} +: 4];
        dpb = dp[idx];
        return {24'h0, dpb, 3'b000, dig};
    endfunction

    // Control FSM. Outputs are registered together with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_dp    <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            psel    <= 1'b0;
            penable <= 1'b0;
            paddr   <= '0;
            pwrite  <= 1'b0;
            pwdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy  <= 1'b1;
                        r_dp  <= dp_mask;
                        r_idx <= '0;
                        r_cnt <= '0;
                        if (hex_mode) begin
                            // No conversion: the first transfer starts right away.
                            r_bin   <= bin_value;
                            r_bcd   <= w_hex_bcd;
                            ovf     <= 1'b0;
                            psel    <= 1'b1;
                            penable <= 1'b0;
                            pwrite  <= 1'b1;
                            paddr   <= 4'h0;
                            pwdata  <= f_word(w_hex_bcd, 3'd0, dp_mask);
                            r_state <= S_SETUP;
                        end else begin
                            r_bin   <= w_over ? SAT_BIN : bin_value;
                            r_bcd   <= '0;
                            ovf     <= w_over;
                            r_state <= S_CONV;
                        end
                    end
                end

                S_CONV: begin
                    r_bcd <= w_bcd_next;
                    r_bin <= r_bin << 1;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_IT) begin
                        // Digit 0 comes from the final shift, which lands on this same edge.
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        pwrite  <= 1'b1;
                        paddr   <= 4'h0;
                        pwdata  <= f_word(w_bcd_next, 3'd0, r_dp);
                        r_state <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    penable <= 1'b1;
                    r_state <= S_ACCESS;
                end

                S_ACCESS: begin
                    penable <= 1'b0;
                    if (r_idx < 3'd5) begin
                        r_idx   <= r_idx + 3'd1;
                        paddr   <= 4'(r_idx + 3'd1);
                        pwdata  <= f_word(r_bcd, r_idx + 3'd1, r_dp);
                        r_state <= S_SETUP;
                    end else begin
                        psel    <= 1'b0;
                        pwrite  <= 1'b0;
                        paddr   <= '0;
                        pwdata  <= '0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
